// File: rtl/seg7_scan_display_if.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_display_if
// Description : Bundle between the syscall display/halt registers and the
//               7-segment scan driver.
//               master : drives en, load, value, halt; observes the pins
//               slave  : the scan driver (consumes inputs, drives the pins)
//   en     1   scan enable; low freezes the scan and darkens the display
//   load   1   one-cycle strobe capturing value
//   value  32  word to display, value[3:0] is the rightmost digit
//   halt   1   CPU halted indicator (lights decimal points)
//   an_n   8   anode selects, active-low, at most one low
//   seg_n  7   segments {g,f,e,d,c,b,a}, active-low
//   dp_n   1   decimal point, active-low
// Revision    : 1.0 - initial release
// ============================================================================
interface seg7_scan_display_if;
    logic        en;
    logic        load;
    logic [31:0] value;
    logic        halt;
    logic [7:0]  an_n;
    logic [6:0]  seg_n;
    logic        dp_n;

    modport master (
        output en, load, value, halt,
        input  an_n, seg_n, dp_n
    );

    modport slave (
        input  en, load, value, halt,
        output an_n, seg_n, dp_n
    );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_display.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_display
// Description : Drives an 8-digit common-anode 7-segment display from a
//               32-bit word. Each digit is preceded by a blanking gap to
//               suppress ghosting; new words are committed only at the end
//               of a frame so a frame never mixes two words. Decimal points
//               light while the CPU is halted.
// Ports       : clk    - system clock, rising edge
//               rst_n  - asynchronous active-low reset
//               bus    - seg7_scan_display_if.slave (en, load, value, halt,
//                        an_n, seg_n, dp_n)
// Parameters  : DIV_CYCLES   - cycles each digit is lit (>= 1)
//               BLANK_CYCLES - dark cycles before each digit (>= 1)
// Options     : LEADING_ZERO_BLANK_EN - when defined, leading zero digits
//               (other than digit 0) show no segments.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_display #(
    parameter int DIV_CYCLES   = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    seg7_scan_display_if.slave    bus
);

    localparam int CNT_MAX = (DIV_CYCLES > BLANK_CYCLES) ? DIV_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] C_DIV_LAST   = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [2:0]       C_LAST_DIGIT = 3'd7;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       r_digit;
    logic [2:0]       w_digit_nxt;
    logic             w_commit;

    logic [31:0]      r_shadow;
    logic [31:0]      r_pending;
    logic             r_pend_v;

    logic [3:0]       w_nibble;
    logic [6:0]       w_seg_lit;
    logic             w_lit_nxt;

    logic [7:0]       r_an_n;
    logic [6:0]       r_seg_n;
    logic             r_dp_n;

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Scan state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BLANK;
            r_cnt   <= '0;
            r_digit <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_digit <= w_digit_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; everything holds while en is low
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_digit_nxt = r_digit;
        w_commit    = 1'b0;
        if (bus.en) begin
            case (r_state)
                ST_BLANK: begin
                    if (r_cnt == C_BLANK_LAST) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_ON;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                ST_ON: begin
                    if (r_cnt == C_DIV_LAST) begin
                        w_cnt_nxt   = '0;
                        w_digit_nxt = r_digit + 3'd1;
                        w_state_nxt = ST_BLANK;
                        // End of the last digit is the only frame boundary
                        w_commit    = (r_digit == C_LAST_DIGIT);
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_BLANK;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Double-buffered display word. A load coinciding with the commit
    // edge bypasses the pending buffer so it is not lost.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow  <= '0;
            r_pending <= '0;
            r_pend_v  <= 1'b0;
        end else if (w_commit) begin
            if (bus.load) begin
                r_shadow  <= bus.value;
                r_pending <= bus.value;
            end else if (r_pend_v) begin
                r_shadow  <= r_pending;
            end
            r_pend_v <= 1'b0;
        end else if (bus.load) begin
            r_pending <= bus.value;
            r_pend_v  <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Segment pattern for the digit about to be shown. Outputs are
    // registered from the next state so a digit is lit exactly for the
    // cycles following the BLANK->ON edge.
    // ------------------------------------------------------------------
`ifdef LEADING_ZERO_BLANK_EN
    logic w_upper_zero;
`endif

    always_comb begin
        w_nibble  = r_shadow[{w_digit_nxt, 2'b00} +: 4];
        w_seg_lit = hex7(w_nibble);
`ifdef LEADING_ZERO_BLANK_EN
        // This nibble and every higher one are zero -> suppress the digit,
        // but keep digit 0 so an all-zero word still shows a single '0'.
        w_upper_zero = ((r_shadow >> {w_digit_nxt, 2'b00}) == 32'd0);
        if ((w_digit_nxt != 3'd0) && w_upper_zero) begin
            w_seg_lit = 7'h7F;
        end
`endif
        w_lit_nxt = bus.en && (w_state_nxt == ST_ON);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an_n  <= 8'hFF;
            r_seg_n <= 7'h7F;
            r_dp_n  <= 1'b1;
        end else if (w_lit_nxt) begin
            r_an_n  <= ~(8'b0000_0001 << w_digit_nxt);
            r_seg_n <= w_seg_lit;
            r_dp_n  <= ~bus.halt;
        end else begin
            r_an_n  <= 8'hFF;
            r_seg_n <= 7'h7F;
            r_dp_n  <= 1'b1;
        end
    end

    assign bus.an_n  = r_an_n;
    assign bus.seg_n = r_seg_n;
    assign bus.dp_n  = r_dp_n;

endmodule
`default_nettype wire
